booth_mult32: RTL and testbench

BOOTH_MULT32 -- requirements
Module: booth_mult32

---
 rtl/mult_pkg.sv | 17 +
 rtl/booth_step.sv | 29 ++
 rtl/booth_mult32.sv | 99 +++++++++
 tb/tb_booth_mult32.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the radix-2 Booth multiplier: FSM states and iteration count.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int BOOTH_ITERS = 33;

    // One extra iteration covers the sign/zero extension bit of the multiplier.
    function automatic int booth_iters(input int width);
        return width + 1;
    endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth iteration: add/sub M by {Q[0], q(-1)}, then arithmetic shift right.
module booth_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0] acc,
    input  logic [WIDTH:0] q,
    input  logic           qm1,
    input  logic [WIDTH:0] m,
    output logic [WIDTH:0] acc_n,
    output logic [WIDTH:0] q_n,
    output logic           qm1_n
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum = acc;
        case ({q[0], qm1})
            2'b01:   sum = acc + m;
            2'b10:   sum = acc - m;
            default: sum = acc;
        endcase
    end

    assign acc_n = {sum[WIDTH], sum[WIDTH:1]};
    assign q_n   = {sum[0], q[WIDTH:1]};
    assign qm1_n = q[0];

endmodule

// File: rtl/booth_mult32.sv
// Sequential radix-2 Booth multiplier, WIDTH+1 iterations, result held in hi/lo until the next completion.
// Optional BOOTH_MULTU_EN adds an is_unsigned port selecting zero-extension (MULTU) instead of sign-extension.
module booth_mult32
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             start,
`ifdef BOOTH_MULTU_EN
    input  logic             is_unsigned,
`endif
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             done,
    output logic             busy
);

    localparam int ITERS = booth_iters(WIDTH);
    localparam int CW    = $clog2(ITERS + 1);
    localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

    state_t         state;
    logic [WIDTH:0] acc, q, m;
    logic           qm1;
    logic [CW-1:0]  cnt;
    logic [WIDTH:0] acc_n, q_n;
    logic           qm1_n;
    logic           sext;

`ifdef BOOTH_MULTU_EN
    assign sext = ~is_unsigned;
`else
    assign sext = 1'b1;
`endif

    booth_step #(.WIDTH(WIDTH)) u_step (
        .acc   (acc),
        .q     (q),
        .qm1   (qm1),
        .m     (m),
        .acc_n (acc_n),
        .q_n   (q_n),
        .qm1_n (qm1_n)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            acc   <= '0;
            q     <= '0;
            m     <= '0;
            qm1   <= 1'b0;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        m     <= {sext & a[WIDTH-1], a};
                        q     <= {sext & b[WIDTH-1], b};
                        acc   <= '0;
                        qm1   <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_n;
                    q   <= q_n;
                    qm1 <= qm1_n;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        // Low 2*WIDTH bits of the (2*WIDTH+2)-bit {acc, Q} after the final shift.
                        hi    <= {acc_n[WIDTH-2:0], q_n[WIDTH]};
                        lo    <= q_n[WIDTH-1:0];
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult32.sv
// Scoreboard bench for booth_mult32: stimulus pushes expected products, a negedge monitor pops on done.
module tb_booth_mult32;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] a = '0, b = '0;
    logic        start = 1'b0;
    logic        is_unsigned = 1'b0;
    logic [31:0] hi, lo;
    logic        done, busy;

    typedef struct {
        logic [63:0] prod;
        int          t0;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    booth_mult32 #(.WIDTH(32)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .a           (a),
        .b           (b),
        .start       (start),
`ifdef BOOTH_MULTU_EN
        .is_unsigned (is_unsigned),
`endif
        .hi          (hi),
        .lo          (lo),
        .done        (done),
        .busy        (busy)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic logic [63:0] ref_mult(input logic [31:0] x, input logic [31:0] y, input bit uns);
        longint          sx, sy;
        longint unsigned ux, uy;
        if (uns) begin
            ux = x;
            uy = y;
            return ux * uy;
        end
        sx = $signed(x);
        sy = $signed(y);
        return sx * sy;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding request, 34 cycles after its start cycle.
    always @(negedge Clk) begin
        if (done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("product", {hi, lo}, e.prod);
                check("latency", 64'(cyc - e.t0), 64'd34);
            end
        end
    end

    // Drive a one-cycle start from IDLE; operands are scrambled right after acceptance.
    task automatic do_mult(input logic [31:0] x, input logic [31:0] y, input bit uns,
                           input logic [63:0] expd);
        int guard;
        exp_t e;
        guard = 0;
        @(negedge Clk);
        while (busy && guard < 100) begin
            @(negedge Clk);
            guard++;
        end
        if (busy) check("idle_timeout", 64'd1, 64'd0);
        a = x;
        b = y;
        is_unsigned = uns;
        start = 1'b1;
        e.prod = expd;
        e.t0 = cyc;
        sb_q.push_back(e);
        @(posedge Clk);
        #1;
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        is_unsigned = $urandom_range(0, 1);
    endtask

    task automatic wait_done(output int nbusy);
        bit seen;
        seen = 1'b0;
        nbusy = 0;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge Clk);
            if (busy) nbusy++;
            if (done) seen = 1'b1;
        end
        if (!seen) check("done_timeout", 64'd0, 64'd1);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int  nb;
        bit  seen;
        bit  uns;
        logic [31:0] x, y;

        repeat (3) @(negedge Clk);
        check("reset_hi_lo", {hi, lo}, 64'd0);
        check("reset_done_busy", {62'd0, done, busy}, 64'd0);
        Reset = 1'b0;

        do_mult(32'd7, 32'd6, 1'b0, 64'h0000_0000_0000_002A);
        wait_done(nb);
        check("busy_cycles_7x6", 64'(nb), 64'd34);
        @(negedge Clk);
        check("busy_after_done", {63'd0, busy}, 64'd0);

        // 2*3 with a stray 9*9 request mid-run: ignored, previous result held until completion.
        do_mult(32'd2, 32'd3, 1'b0, 64'd6);
        seen = 1'b0;
        for (int i = 1; i <= 60 && !seen; i++) begin
            @(negedge Clk);
            if (i == 9) begin
                a = 32'd9;
                b = 32'd9;
                start = 1'b1;
            end
            if (i == 10) start = 1'b0;
            if (done) seen = 1'b1;
            else check("hold_during_run", {hi, lo}, 64'h0000_0000_0000_002A);
        end
        if (!seen) check("done_timeout_2x3", 64'd0, 64'd1);

        // Start asserted in DONE must not be accepted.
        a = 32'd9;
        b = 32'd9;
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        check("start_in_done_ignored", {63'd0, busy}, 64'd0);
        check("hold_after_done", {hi, lo}, 64'd6);

        do_mult(32'hFFFF_FFFD, 32'd5, 1'b0, 64'hFFFF_FFFF_FFFF_FFF1);
        wait_done(nb);
        do_mult(32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000);
        wait_done(nb);

        // Reset partway through a run.
        do_mult(32'd5, 32'd5, 1'b0, 64'd25);
        repeat (14) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        check("midrun_reset_hi_lo", {hi, lo}, 64'd0);
        check("midrun_reset_done_busy", {62'd0, done, busy}, 64'd0);
        sb_q.delete();
        Reset = 1'b0;
        do_mult(32'd4, 32'd4, 1'b0, 64'h10);
        wait_done(nb);
        check("busy_cycles_4x4", 64'(nb), 64'd34);

`ifdef BOOTH_MULTU_EN
        do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFE_0000_0001);
        wait_done(nb);
        do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'h0000_0000_0000_0001);
        wait_done(nb);
`endif

        for (int k = 0; k < 30; k++) begin
            x = pick_operand();
            y = pick_operand();
`ifdef BOOTH_MULTU_EN
            uns = 1'($urandom_range(0, 1));
`else
            uns = 1'b0;
`endif
            do_mult(x, y, uns, ref_mult(x, y, uns));
            wait_done(nb);
        end

        @(negedge Clk);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
